demux64_1_4: RTL
================

# demux64_1_4

Streaming 1-to-4 distributor for 64-bit words: accepts one word per cycle on a valid/ready input together with a 2-bit lane select, and delivers it to the selected output lane through a small per-lane FIFO. It is the sending-side counterpart of the 4:1 64-bit word multiplexer: it fans a single word stream out to four consumers, each with independent backpressure. It sits between a single producer and four downstream channels.

## Interface
- WIDTH, 64, data word width
- DEPTH, 2, entries per lane FIFO; power of two, ≥ 2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer offers a word
- in_ready  output  1  block accepts the offered word this cycle
- in_sel  input  2  destination lane 0..3; sampled with in_data
- in_data  input  WIDTH  word to route
- out_valid  output  4  bit i: lane i FIFO non-empty
- out_ready  input  4  bit i: consumer i takes the head word
- out_data0..out_data3  output  WIDTH each  head word of lane i

## Operation
- Transfer on input when in_valid && in_ready at a rising edge; word pushed into FIFO[in_sel].
- in_ready = !full[in_sel], combinational from in_sel and lane state; not dependent on out_ready (no pass-through when full).
- Pop on lane i when out_valid[i] && out_ready[i] at a rising edge.
- out_data_i = head entry of lane i; holds value while out_valid[i] && !out_ready[i]; contents undefined-but-stable (last value) when empty, 0 after reset.
- Per lane: write pointer, read pointer, count (log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Simultaneous push and pop on same non-full, non-empty lane: count unchanged, both pointers advance.
- Push into empty lane with pop on another lane: independent; lanes never interact.
- Order preserved within a lane; no ordering guarantee across lanes.
- in_sel/in_data ignored when in_valid = 0; in_ready still reflects the currently selected lane.
- No word dropped or duplicated; a full lane stalls the input, including words for other lanes behind it (head-of-line blocking is intended).

## Timing
- Reset (async assert, any time, including mid-transfer): all counts and pointers 0, out_valid = 4'b0000, out_data0..3 = 0, in_ready = 1 while rst low again and after release. Words in flight are discarded.
- Latency: word accepted at edge N → out_valid[sel] = 1 and out_data_sel = word in the cycle after edge N.
- Throughput: one input word per cycle while selected lane not full; each lane drains one word per cycle.
- Full lane: in_ready = 0 for that sel in the cycle count = DEPTH; returns to 1 in the cycle after a pop on that lane.
- Empty: out_valid[i] falls in the cycle after the edge that pops the last entry with no push.

## Structure
- Shared include/package: LANES = 4, SEL_W = 2, default WIDTH = 64, DEPTH = 2.
- One sub-module: demux_lane_fifo (WIDTH, DEPTH; push, pop, din, dout, full, empty), instantiated four times; top holds one-hot decode of in_sel, in_ready select, and output wiring.

## Test plan
- Reset then push 64'hA0..A3 with in_sel 0,1,2,3 on consecutive cycles, all out_ready = 1 → each appears on its lane exactly one cycle after acceptance; out_valid one-hot per cycle.
- out_ready = 0, push 3 words to lane 2 (DEPTH 2) → in_ready drops after 2 accepts, 3rd held; raise out_ready[2] for one cycle → 3rd word accepted next cycle; lane 2 drains in push order.
- Lane 1 full, in_sel = 1 with in_valid → in_ready = 0; switch in_sel to 3 → in_ready = 1 and word lands on lane 3.
- Lane 0 holding 1 word, simultaneous push and pop on lane 0 for 10 cycles with incrementing data → count stays 1, pointers wrap, output sequence has no gaps or repeats.
- Assert rst mid-stream with lanes partly full → out_valid = 0, out_data0..3 = 0 immediately (asynchronous); after release in_ready = 1 and first new word emerges with latency 1.
- Random in_sel/in_valid/out_ready for 10k cycles against a per-lane scoreboard → no loss, duplication or reorder within any lane.

Source files
------------

// File: rtl/demux64_1_4_pkg.sv
// Shared constants for the 1-to-4 word distributor.
// Lane count, select width and default word/FIFO sizes.
package demux64_1_4_pkg;
  localparam int LANES     = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 2;
endpackage

// File: rtl/demux64_1_4_if.sv
// Producer-side and consumer-side bus of the distributor.
// master = producer/consumers, slave = distributor.
interface demux64_1_4_if
  import demux64_1_4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [WIDTH-1:0] in_data;
  logic [LANES-1:0] out_valid;
  logic [LANES-1:0] out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid,
    input  out_data0, out_data1, out_data2, out_data3
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid,
    output out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/demux_lane_fifo.sv
// Per-lane FIFO; head entry drives dout directly.
// Storage resets to zero so dout reads 0 after reset.
module demux_lane_fifo
  import demux64_1_4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/demux64_1_4.sv
// 1-to-4 streaming word distributor with per-lane FIFOs.
// A full selected lane stalls the whole input stream.
module demux64_1_4
  import demux64_1_4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  demux64_1_4_if.slave bus
);
  logic [LANES-1:0] w_sel_oh;
  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_empty;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;
  logic [WIDTH-1:0] w_dout [LANES];
  logic             w_xfer;

  assign w_sel_oh     = LANES'(1) << bus.in_sel;
  assign bus.in_ready = ~w_full[bus.in_sel];
  assign w_xfer       = bus.in_valid & bus.in_ready;
  assign w_push       = w_sel_oh & {LANES{w_xfer}};
  assign w_pop        = ~w_empty & bus.out_ready;
  assign bus.out_valid = ~w_empty;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_din   (bus.in_data),
      .o_dout  (w_dout[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign bus.out_data0 = w_dout[0];
  assign bus.out_data1 = w_dout[1];
  assign bus.out_data2 = w_dout[2];
  assign bus.out_data3 = w_dout[3];
endmodule
